// File: rtl/bottle_seq_ctrl.sv
// Batch sequencer for the pill-bottling datapath: operator keys, BCD target entry,
// paced pill-drop tick generation and timed batch-complete alarm.
module bottle_seq_ctrl #(
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned ALARM_CYC = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_set,
    input  logic       key_digit_vld,
    input  logic [3:0] key_digit,
    input  logic       sel_field,
    input  logic       allFull,
    output logic [3:0] maxL,
    output logic [3:0] maxH,
    output logic [3:0] bot_maxL,
    output logic [3:0] bot_maxH,
    output logic       isWork,
    output logic       EN_set,
    output logic       clr,
    output logic       pill_tick,
    output logic       alarm,
    output logic       cfg_err,
    output logic [2:0] state
);

    localparam int unsigned DW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ALARM_CYC + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_TOP = AW'(ALARM_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        FULL  = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [DW-1:0] div, div_nxt;
    logic [AW-1:0] acnt, acnt_nxt;
    logic [3:0]    maxL_nxt, maxH_nxt, bot_maxL_nxt, bot_maxH_nxt;
    logic          clr_nxt, tick_nxt, alarm_nxt, cfg_err_nxt, tgt_ok;

    assign state = cur;

    always_comb begin
        nxt          = cur;
        div_nxt      = div;
        acnt_nxt     = acnt;
        maxL_nxt     = maxL;
        maxH_nxt     = maxH;
        bot_maxL_nxt = bot_maxL;
        bot_maxH_nxt = bot_maxH;
        clr_nxt      = 1'b0;
        tick_nxt     = 1'b0;
        alarm_nxt    = 1'b0;
        cfg_err_nxt  = 1'b0;
        tgt_ok       = ({maxH, maxL} != 8'h00) && ({bot_maxH, bot_maxL} != 8'h00);

        // A pause key, even where it has no effect, still masks a same-cycle start.
        case (cur)
            IDLE: begin
                if (key_set) begin
                    nxt = SET;
                end else if (key_start && !key_pause) begin
                    if (tgt_ok) begin
                        nxt     = RUN;
                        clr_nxt = 1'b1;
                        div_nxt = '0;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            SET: begin
                if (key_set) nxt = IDLE;
                if (key_digit_vld && key_digit <= 4'd9) begin
                    if (sel_field) begin
                        bot_maxH_nxt = bot_maxL;
                        bot_maxL_nxt = key_digit;
                    end else begin
                        maxH_nxt = maxL;
                        maxL_nxt = key_digit;
                    end
                end
            end
            RUN: begin
                if (key_set) begin
                    nxt = SET;
                end else if (key_pause) begin
                    nxt = PAUSE;
                end else if (allFull) begin
                    nxt       = FULL;
                    alarm_nxt = 1'b1;
                    acnt_nxt  = ALARM_TOP;
                end else if (div == DIV_LAST) begin
                    div_nxt  = '0;
                    tick_nxt = 1'b1;
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            PAUSE: begin
                if (key_set) nxt = SET;
                else if (key_start && !key_pause) nxt = RUN;
            end
            FULL: begin
                if (key_set) begin
                    nxt      = SET;
                    acnt_nxt = '0;
                end else if (key_start && !key_pause) begin
                    nxt      = RUN;
                    clr_nxt  = 1'b1;
                    div_nxt  = '0;
                    acnt_nxt = '0;
                end else if (acnt != '0) begin
                    acnt_nxt  = acnt - 1'b1;
                    alarm_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur       <= IDLE;
            div       <= '0;
            acnt      <= '0;
            maxL      <= '0;
            maxH      <= '0;
            bot_maxL  <= '0;
            bot_maxH  <= '0;
            isWork    <= 1'b0;
            EN_set    <= 1'b0;
            clr       <= 1'b0;
            pill_tick <= 1'b0;
            alarm     <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cur       <= nxt;
            div       <= div_nxt;
            acnt      <= acnt_nxt;
            maxL      <= maxL_nxt;
            maxH      <= maxH_nxt;
            bot_maxL  <= bot_maxL_nxt;
            bot_maxH  <= bot_maxH_nxt;
            isWork    <= (nxt == RUN) || (nxt == PAUSE);
            EN_set    <= (nxt == SET);
            clr       <= clr_nxt;
            pill_tick <= tick_nxt;
            alarm     <= alarm_nxt;
            cfg_err   <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_bottle_seq_ctrl.sv
// Directed bench for bottle_seq_ctrl: table of single-cycle key vectors plus
// hand-written tick pacing, pause/resume, full/alarm and async reset sequences.
module tb_bottle_seq_ctrl;

    logic       CLK, RST;
    logic       key_start, key_pause, key_set, key_digit_vld, sel_field, allFull;
    logic [3:0] key_digit;
    logic [3:0] maxL, maxH, bot_maxL, bot_maxH;
    logic       isWork, EN_set, clr, pill_tick, alarm, cfg_err;
    logic [2:0] state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bottle_seq_ctrl #(.TICK_DIV(4), .ALARM_CYC(8)) dut (
        .CLK(CLK), .RST(RST),
        .key_start(key_start), .key_pause(key_pause), .key_set(key_set),
        .key_digit_vld(key_digit_vld), .key_digit(key_digit),
        .sel_field(sel_field), .allFull(allFull),
        .maxL(maxL), .maxH(maxH), .bot_maxL(bot_maxL), .bot_maxH(bot_maxH),
        .isWork(isWork), .EN_set(EN_set), .clr(clr), .pill_tick(pill_tick),
        .alarm(alarm), .cfg_err(cfg_err), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // flags = {isWork, EN_set, clr, pill_tick, alarm, cfg_err}
    typedef struct {
        logic       st, ps, se, dv;
        logic [3:0] dg;
        logic       sf, af;
        logic [2:0] est;
        logic [7:0] emax, ebot;
        logic [5:0] eflg;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic st, ps, se, dv, input logic [3:0] dg,
                                input logic sf, input logic [2:0] est,
                                input logic [7:0] emax, ebot, input logic [5:0] eflg);
        vec_t v;
        v.st = st; v.ps = ps; v.se = se; v.dv = dv; v.dg = dg; v.sf = sf; v.af = 1'b0;
        v.est = est; v.emax = emax; v.ebot = ebot; v.eflg = eflg;
        return v;
    endfunction

    function automatic logic [7:0] flags();
        return {2'b00, isWork, EN_set, clr, pill_tick, alarm, cfg_err};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        key_start = 0; key_pause = 0; key_set = 0; key_digit_vld = 0;
        key_digit = 0; sel_field = 0; allFull = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic st, input logic ps, input logic se);
        key_start = st; key_pause = ps; key_set = se;
        step();
        key_start = 0; key_pause = 0; key_set = 0;
    endtask

    initial begin
        idle_in();
        RST = 1'b1;
        step();
        chk("reset_state", {5'd0, state}, 8'd0);
        chk("reset_flags", flags(), 8'h00);
        chk("reset_targets", {maxH, maxL}, 8'h00);
        #2 RST = 1'b0;

        vecs[0]  = mk(1,0,0,0,4'h0,0, 3'd0, 8'h00, 8'h00, 6'b000001);
        vecs[1]  = mk(0,0,0,0,4'h0,0, 3'd0, 8'h00, 8'h00, 6'b000000);
        vecs[2]  = mk(0,0,1,0,4'h0,0, 3'd1, 8'h00, 8'h00, 6'b010000);
        vecs[3]  = mk(0,0,0,1,4'h1,0, 3'd1, 8'h01, 8'h00, 6'b010000);
        vecs[4]  = mk(0,0,0,1,4'h2,0, 3'd1, 8'h12, 8'h00, 6'b010000);
        vecs[5]  = mk(0,0,0,1,4'hA,0, 3'd1, 8'h12, 8'h00, 6'b010000);
        vecs[6]  = mk(0,0,1,0,4'h0,0, 3'd0, 8'h12, 8'h00, 6'b000000);
        vecs[7]  = mk(1,0,0,0,4'h0,0, 3'd0, 8'h12, 8'h00, 6'b000001);
        vecs[8]  = mk(0,0,0,0,4'h0,0, 3'd0, 8'h12, 8'h00, 6'b000000);
        vecs[9]  = mk(0,0,1,0,4'h0,0, 3'd1, 8'h12, 8'h00, 6'b010000);
        vecs[10] = mk(0,0,0,1,4'h3,1, 3'd1, 8'h12, 8'h03, 6'b010000);
        vecs[11] = mk(1,1,0,0,4'h0,0, 3'd1, 8'h12, 8'h03, 6'b010000);
        vecs[12] = mk(0,0,1,0,4'h0,0, 3'd0, 8'h12, 8'h03, 6'b000000);
        vecs[13] = mk(1,0,0,0,4'h0,0, 3'd2, 8'h12, 8'h03, 6'b101000);
        vecs[14] = mk(0,0,0,0,4'h0,0, 3'd2, 8'h12, 8'h03, 6'b100000);

        for (int i = 0; i < 15; i++) begin
            key_start = vecs[i].st; key_pause = vecs[i].ps; key_set = vecs[i].se;
            key_digit_vld = vecs[i].dv; key_digit = vecs[i].dg;
            sel_field = vecs[i].sf; allFull = vecs[i].af;
            step();
            chk($sformatf("vec%0d_state", i), {5'd0, state}, {5'd0, vecs[i].est});
            chk($sformatf("vec%0d_max", i), {maxH, maxL}, vecs[i].emax);
            chk($sformatf("vec%0d_bot", i), {bot_maxH, bot_maxL}, vecs[i].ebot);
            chk($sformatf("vec%0d_flags", i), flags(), {2'b00, vecs[i].eflg});
        end
        idle_in();

        // RUN cycle 1 now; ticks due on cycles 4, 8, 12
        for (int k = 2; k <= 14; k++) begin
            step();
            chk($sformatf("run_tick_c%0d", k), {7'd0, pill_tick}, {7'd0, (k % 4 == 0)});
            chk($sformatf("run_clr_c%0d", k), {7'd0, clr}, 8'd0);
        end

        // divider is 2: pause, hold 10 cycles, resume
        pulse(0, 1, 0);
        chk("pause_state", {5'd0, state}, 8'd3);
        chk("pause_flags", flags(), 8'b00100000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("paused_tick%0d", k), {7'd0, pill_tick}, 8'd0);
        end
        pulse(1, 0, 0);
        chk("resume_state", {5'd0, state}, 8'd2);
        chk("resume_flags", flags(), 8'b00100000);
        step();
        chk("resume_c1_tick", {7'd0, pill_tick}, 8'd0);
        step();
        chk("resume_c2_tick", {7'd0, pill_tick}, 8'd1);

        // advance to divider=3 so allFull coincides with a wrap
        repeat (3) step();
        allFull = 1'b1;
        step();
        chk("full_state", {5'd0, state}, 8'd4);
        chk("full_flags", flags(), 8'b00000010);
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("alarm_c%0d", k), {6'd0, alarm, pill_tick}, 8'b10);
        end
        step();
        chk("alarm_off", {6'd0, alarm, pill_tick}, 8'b00);
        chk("full_hold", {5'd0, state}, 8'd4);

        allFull = 1'b0;
        pulse(1, 0, 0);
        chk("restart_state", {5'd0, state}, 8'd2);
        chk("restart_flags", flags(), 8'b00101000);

        // re-enter FULL and restart while alarm is still high
        allFull = 1'b1;
        step();
        allFull = 1'b0;
        step();
        chk("full2_alarm", {5'd0, state, alarm}, 8'b1001);
        pulse(1, 0, 0);
        chk("restart2_flags", {5'd0, state} << 6 | flags(), 8'b10101000);

        pulse(0, 1, 1);
        chk("set_pause_state", {5'd0, state}, 8'd1);
        chk("set_pause_flags", flags(), 8'b00010000);

        // async reset in the middle of a RUN cycle
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        step();
        step();
        chk("pre_reset_state", {5'd0, state}, 8'd2);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_state", {5'd0, state}, 8'd0);
        chk("async_rst_flags", flags(), 8'h00);
        chk("async_rst_max", {maxH, maxL}, 8'h00);
        chk("async_rst_bot", {bot_maxH, bot_maxL}, 8'h00);
        step();
        #2 RST = 1'b0;
        step();
        chk("post_reset_state", {5'd0, state}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
